// File: rtl/sha256_msg_schedule_ctrl.sv
// -----------------------------------------------------------------------------
// sha256_msg_schedule_ctrl
//
// Sequences the SHA-256 message schedule for one 512-bit block.
//   * Accepts 16 message words (M[0] first) over a valid/ready port and stores
//     them in a 16-entry circular buffer.
//   * Streams W[0..63] to the compression core, one word per handshake.
//   * Words W[16..63] are computed from the buffer and written back in place,
//     so the buffer always holds the 16 most recent schedule words.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous, active-high reset
//   start      in   1   begins a block; honoured only in IDLE
//   msg_valid  in   1   msg_word is valid
//   msg_word   in  32   message word, big-endian, M[0] first
//   msg_ready  out  1   message word accepted this cycle when msg_valid (LOAD)
//   w_valid    out  1   w_out / w_index valid (GEN)
//   w_ready    in   1   consumer takes w_out this cycle
//   w_out      out 32   schedule word W[w_index] (0 when w_valid is low)
//   w_index    out  6   round index t (0 when w_valid is low)
//   busy       out  1   high in LOAD, GEN and DONE
//   done       out  1   one-cycle pulse after the W[63] handshake
// -----------------------------------------------------------------------------
module sha256_msg_schedule_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        msg_valid,
  input  logic [31:0] msg_word,
  output logic        msg_ready,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_out,
  output logic [5:0]  w_index,
  output logic        busy,
  output logic        done
);

  // Both sizes are fixed by SHA-256.
  localparam int ROUNDS = 64;
  localparam int BUF_D  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_GEN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [3:0]  load_cnt_r;
  logic [5:0]  t_r;
  logic [31:0] buf_r [BUF_D];

  logic        msg_acc_s;
  logic        w_acc_s;
  logic [3:0]  idx_m2_s;
  logic [3:0]  idx_m7_s;
  logic [3:0]  idx_m15_s;
  logic [3:0]  idx_m16_s;
  logic [31:0] w_calc_s;
  logic [31:0] w_word_s;

  // SHA-256 small sigma0: ROTR7 ^ ROTR18 ^ SHR3.
  function automatic logic [31:0] sigma0_func_schedule(input logic [31:0] x);
    sigma0_func_schedule = {x[6:0],  x[31:7]}  ^
                           {x[17:0], x[31:18]} ^
                           {3'b000,  x[31:3]};
  endfunction

  // SHA-256 small sigma1: ROTR17 ^ ROTR19 ^ SHR10.
  function automatic logic [31:0] sigma1_func_schedule(input logic [31:0] x);
    sigma1_func_schedule = {x[16:0], x[31:17]} ^
                           {x[18:0], x[31:19]} ^
                           {10'b00_0000_0000, x[31:10]};
  endfunction

  // Next-state and state-decoded control outputs.
  always_comb begin
    state_s   = state_r;
    msg_ready = 1'b0;
    w_valid   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        msg_ready = 1'b1;
        busy      = 1'b1;
        if (msg_valid && (load_cnt_r == 4'(BUF_D - 1))) begin
          state_s = ST_GEN;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_GEN: begin
        w_valid = 1'b1;
        busy    = 1'b1;
        if (w_ready && (t_r == 6'(ROUNDS - 1))) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_GEN;
        end
      end
      ST_DONE: begin
        // start is deliberately not looked at here.
        done    = 1'b1;
        busy    = 1'b1;
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  assign msg_acc_s = msg_valid && msg_ready;
  assign w_acc_s   = w_valid && w_ready;

  // Circular-buffer taps for W[t-2], W[t-7], W[t-15], W[t-16]; mod-16 wrap is free.
  always_comb begin
    idx_m2_s  = t_r[3:0] - 4'd2;
    idx_m7_s  = t_r[3:0] - 4'd7;
    idx_m15_s = t_r[3:0] - 4'd15;
    idx_m16_s = t_r[3:0];
  end

  // Schedule word for the current round; arithmetic wraps mod 2^32.
  always_comb begin
    w_calc_s = sigma1_func_schedule(buf_r[idx_m2_s]) + buf_r[idx_m7_s] +
               sigma0_func_schedule(buf_r[idx_m15_s]) + buf_r[idx_m16_s];
    if (t_r < 6'(BUF_D)) begin
      w_word_s = buf_r[idx_m16_s];
    end else begin
      w_word_s = w_calc_s;
    end
  end

  // Data outputs are forced to zero whenever no word is being offered.
  always_comb begin
    if (w_valid) begin
      w_out   = w_word_s;
      w_index = t_r;
    end else begin
      w_out   = 32'd0;
      w_index = 6'd0;
    end
  end

  // State register and load/round counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      load_cnt_r <= 4'd0;
      t_r        <= 6'd0;
    end else begin
      state_r <= state_s;
      if ((state_r == ST_IDLE) && start) begin
        load_cnt_r <= 4'd0;
        t_r        <= 6'd0;
      end else if (msg_acc_s) begin
        // Wraps to 0 on the 16th word, so the counter never passes 15.
        load_cnt_r <= load_cnt_r + 4'd1;
      end else if (w_acc_s && (t_r != 6'(ROUNDS - 1))) begin
        t_r <= t_r + 6'd1;
      end
    end
  end

  // Buffer writes: message words in LOAD, computed words written back in GEN.
  // Contents are intentionally never cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && msg_acc_s) begin
      buf_r[load_cnt_r] <= msg_word;
    end else if (!rst && w_acc_s && (t_r >= 6'(BUF_D))) begin
      // Slot t&15 held W[t-16], which is no longer needed.
      buf_r[idx_m16_s] <= w_calc_s;
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for sha256_msg_schedule_ctrl.
// Reference: the textbook 64-entry SHA-256 expansion computed from the 16
// message words, compared word-by-word against the streamed output.
// -----------------------------------------------------------------------------
module tb_sha256_msg_schedule_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        msg_valid;
  logic [31:0] msg_word;
  logic        msg_ready;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_out;
  logic [5:0]  w_index;
  logic        busy;
  logic        done;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] cur_m [16];
  logic [31:0] ref_w [64];

  sha256_msg_schedule_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .msg_valid (msg_valid),
    .msg_word  (msg_word),
    .msg_ready (msg_ready),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_out     (w_out),
    .w_index   (w_index),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Hard stop in case something hangs outside a bounded loop.
  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "global timeout");
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_ref();
    for (int t = 0; t < 64; t++) begin
      if (t < 16) ref_w[t] = cur_m[t];
      else ref_w[t] = ref_s1(ref_w[t-2]) + ref_w[t-7] + ref_s0(ref_w[t-15]) + ref_w[t-16];
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) cur_m[i] = 32'h0000_0000;
    cur_m[0]  = 32'h6162_6380;
    cur_m[15] = 32'h0000_0018;
    build_ref();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},      busy,      32'd0);
    chk({tag, "_msg_ready"}, msg_ready, 32'd0);
    chk({tag, "_w_valid"},   w_valid,   32'd0);
    chk({tag, "_done"},      done,      32'd0);
    chk({tag, "_w_out"},     w_out,     32'd0);
    chk({tag, "_w_index"},   w_index,   32'd0);
  endtask

  task automatic start_block();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_load_ready", msg_ready, 32'd1);
    chk("start_busy", busy, 32'd1);
  endtask

  // Feed cur_m; with gaps, msg_valid and start are randomised.
  task automatic load_block(input bit gaps);
    int idx = 0;
    int cyc = 0;
    while (idx < 16 && cyc < 300) begin
      chk("load_msg_ready", msg_ready, 32'd1);
      chk("load_busy", busy, 32'd1);
      chk("load_w_valid", w_valid, 32'd0);
      msg_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      msg_word  = msg_valid ? cur_m[idx] : $urandom;
      start     = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      if (msg_valid) idx++;
      cyc++;
    end
    msg_valid = 1'b0;
    start     = 1'b0;
    chk("load_word_count", idx, 32'd16);
  endtask

  // Consume the 64 words. rst_at >= 0 aborts the block with reset at that round.
  task automatic stream_block(input bit bp, input bit noise, input bit kat,
                              input bit start_in_done, input int rst_at);
    int          idx = 0;
    int          cyc = 0;
    bit          stalled = 1'b0;
    logic [31:0] held_w = 32'd0;
    logic [5:0]  held_i = 6'd0;
    while (idx < 64 && cyc < 1000) begin
      chk("gen_w_valid", w_valid, 32'd1);
      chk("gen_w_index", w_index, idx[5:0]);
      chk("gen_w_out", w_out, ref_w[idx]);
      chk("gen_busy", busy, 32'd1);
      chk("gen_msg_ready", msg_ready, 32'd0);
      chk("gen_done", done, 32'd0);
      if (stalled) begin
        chk("stall_hold_w_out", w_out, held_w);
        chk("stall_hold_w_index", w_index, held_i);
      end
      if (kat && idx == 16) chk("kat_abc_w16", w_out, 32'h6162_6380);
      if (kat && idx == 17) chk("kat_abc_w17", w_out, 32'h000F_0000);
      if (kat && idx == 15) chk("kat_abc_w15", w_out, 32'h0000_0018);
      if (idx == rst_at) begin
        rst     = 1'b1;
        w_ready = 1'b1;
        tick();
        rst     = 1'b0;
        w_ready = 1'b0;
        chk_idle("abort");
        for (int k = 0; k < 5; k++) begin
          tick();
          chk("abort_no_done", done, 32'd0);
          chk("abort_stays_idle", busy, 32'd0);
        end
        return;
      end
      w_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (noise) begin
        msg_valid = 1'($urandom_range(0, 1));
        msg_word  = $urandom;
        start     = 1'($urandom_range(0, 1));
      end
      held_w  = w_out;
      held_i  = w_index;
      stalled = !w_ready;
      tick();
      if (w_ready) idx++;
      cyc++;
    end
    msg_valid = 1'b0;
    chk("gen_word_count", idx, 32'd64);
    chk("done_pulse", done, 32'd1);
    chk("done_busy", busy, 32'd1);
    chk("done_w_valid", w_valid, 32'd0);
    chk("done_w_out", w_out, 32'd0);
    start   = start_in_done;
    w_ready = 1'b0;
    tick();
    start = 1'b0;
    chk_idle("after_done");
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    msg_valid = 1'b0;
    msg_word  = 32'd0;
    w_ready   = 1'b0;
    tick();
    tick();
    chk_idle("reset");
    rst = 1'b0;

    // msg_valid while idle is ignored.
    for (int k = 0; k < 3; k++) begin
      msg_valid = 1'b1;
      msg_word  = $urandom;
      tick();
      chk_idle("idle_msg");
    end
    msg_valid = 1'b0;

    // 1: "abc" block.
    set_abc();
    start_block();
    load_block(1'b0);
    stream_block(1'b0, 1'b0, 1'b1, 1'b0, -1);

    // 2: all-zero block.
    for (int i = 0; i < 16; i++) cur_m[i] = 32'd0;
    build_ref();
    start_block();
    load_block(1'b0);
    stream_block(1'b0, 1'b0, 1'b0, 1'b0, -1);

    // 3: back-pressure on "abc".
    set_abc();
    start_block();
    load_block(1'b0);
    stream_block(1'b1, 1'b0, 1'b1, 1'b0, -1);

    // 4: msg_valid gaps in LOAD, pulses during start and GEN.
    msg_valid = 1'b1;
    msg_word  = 32'hDEAD_BEEF;
    start_block();
    load_block(1'b1);
    stream_block(1'b0, 1'b1, 1'b1, 1'b0, -1);
    start = 1'b0;

    // 5: reset at t=30, then a fresh "abc" block.
    start_block();
    load_block(1'b0);
    stream_block(1'b0, 1'b0, 1'b0, 1'b0, 30);
    start_block();
    load_block(1'b0);
    stream_block(1'b0, 1'b0, 1'b1, 1'b0, -1);

    // 6: start during DONE ignored; then back-to-back random blocks.
    start_block();
    load_block(1'b1);
    stream_block(1'b0, 1'b1, 1'b1, 1'b1, -1);
    tick();
    chk_idle("done_start_ignored");
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 16; i++) cur_m[i] = $urandom;
      build_ref();
      start_block();
      load_block(b == 1);
      stream_block(b != 0, 1'b0, 1'b0, 1'b0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
